// File: rtl/tap_window_feeder_pkg.sv
// Shared types and constants for the 4-tap filter pipeline front end.
package tap_window_feeder_pkg;
    localparam int TW_DATA_W = 16;
    localparam int TW_QFRAC  = 14;
    localparam int NTAPS     = 4;

    typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_FLUSH} tw_state_e;
endpackage

// File: rtl/tap_window_feeder_shift.sv
// NTAPS-deep sample window; tap 0 is the newest entry. A pending clear that
// coincides with a shift loads the new sample into an otherwise empty window.
module tap_window_feeder_shift
    import tap_window_feeder_pkg::*;
#(
    parameter int DATA_W = TW_DATA_W,
    parameter int DEPTH  = NTAPS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_i,
    input  logic                    clr_i,
    input  logic                    zero_i,
    input  logic [DATA_W-1:0]       din_i,
    output logic [DEPTH*DATA_W-1:0] taps_o
);
    logic [DEPTH-1:0][DATA_W-1:0] w_q;

    always_ff @(posedge clk) begin
        if (rst || (clr_i && !shift_i)) begin
            w_q <= '0;
        end else if (shift_i) begin
            w_q[0] <= zero_i ? '0 : din_i;
            for (int k = 1; k < DEPTH; k++)
                w_q[k] <= clr_i ? '0 : w_q[k-1];
        end
    end

    assign taps_o = w_q;
endmodule

// File: rtl/tap_window_feeder.sv
// Serial-to-window feeder for the 4-tap multiply-add datapath.
// Define TAP_WIN_FLUSH_EN to drain each frame with three zero-shifted windows.
module tap_window_feeder
    import tap_window_feeder_pkg::*;
#(
    parameter int DATA_W     = TW_DATA_W,
    parameter int ZERO_PRIME = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_mu,
    input  logic              in_last,
    output logic [DATA_W-1:0] data1_out,
    output logic [DATA_W-1:0] data2_out,
    output logic [DATA_W-1:0] data3_out,
    output logic [DATA_W-1:0] data4_out,
    output logic [DATA_W-1:0] mu_out,
    output logic              enable_out,
    output logic              frame_done
);
    tw_state_e               state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    clr_q, clr_d;
    logic                    en_q, en_d;
    logic                    done_q, done_d;
    logic [DATA_W-1:0]       mu_q;
    logic                    shift_s, zero_s, accept;
    logic [NTAPS*DATA_W-1:0] taps_s;

`ifdef TAP_WIN_FLUSH_EN
    logic [1:0] fcnt_q, fcnt_d;
    assign in_ready = ~rst & (state_q != ST_FLUSH);
`else
    assign in_ready = ~rst;
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_d   = 1'b0;
        en_d    = 1'b0;
        done_d  = 1'b0;
        shift_s = 1'b0;
        zero_s  = 1'b0;
`ifdef TAP_WIN_FLUSH_EN
        fcnt_d  = fcnt_q;
`endif
        case (state_q)
            ST_FILL: if (accept) begin
                shift_s = 1'b1;
                en_d    = (ZERO_PRIME != 0) || (cnt_q == 2'd3);
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ST_RUN;
            end
            ST_RUN: if (accept) begin
                shift_s = 1'b1;
                en_d    = 1'b1;
            end
`ifdef TAP_WIN_FLUSH_EN
            ST_FLUSH: begin
                shift_s = 1'b1;
                zero_s  = 1'b1;
                en_d    = 1'b1;
                fcnt_d  = fcnt_q + 2'd1;
                if (fcnt_q == 2'd2) begin
                    state_d = ST_FILL;
                    fcnt_d  = 2'd0;
                    done_d  = 1'b1;
                    clr_d   = 1'b1;
                end
            end
`endif
            default: state_d = ST_FILL;
        endcase
        // Frame end: the final window is still strobed, the clear lands one cycle later
        if (accept && in_last) begin
            cnt_d = 2'd0;
`ifdef TAP_WIN_FLUSH_EN
            state_d = ST_FLUSH;
            fcnt_d  = 2'd0;
`else
            state_d = ST_FILL;
            done_d  = 1'b1;
            clr_d   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            cnt_q   <= 2'd0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            mu_q    <= '0;
`ifdef TAP_WIN_FLUSH_EN
            fcnt_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            done_q  <= done_d;
            if (accept) mu_q <= in_mu;
`ifdef TAP_WIN_FLUSH_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    tap_window_feeder_shift #(.DATA_W(DATA_W), .DEPTH(NTAPS)) u_win (
        .clk     (clk),
        .rst     (rst),
        .shift_i (shift_s),
        .clr_i   (clr_q),
        .zero_i  (zero_s),
        .din_i   (in_data),
        .taps_o  (taps_s)
    );

    assign data1_out  = taps_s[0*DATA_W +: DATA_W];
    assign data2_out  = taps_s[1*DATA_W +: DATA_W];
    assign data3_out  = taps_s[2*DATA_W +: DATA_W];
    assign data4_out  = taps_s[3*DATA_W +: DATA_W];
    assign mu_out     = mu_q;
    assign enable_out = en_q;
    assign frame_done = done_q;
endmodule

// File: doc/tap_window_feeder.md
Name: tap_window_feeder

Overview:
- Upstream stage of the 4-tap multiply-add datapath.
- Accepts a serial stream of signed Q2.14 samples with a valid/ready handshake and maintains a 4-deep sliding window.
- Each cycle it presents the window as four parallel taps (data1..data4) with a one-cycle enable strobe, plus the step-size word mu aligned to the newest sample.
- Frame boundaries are marked by in_last. The window is cleared between frames, optionally after a zero-padded tail flush.

Parameters:
DATA_W, 16, sample and mu width (signed, Q2.14 at default).
ZERO_PRIME, 0, 0 = no strobe until 4 samples of the current frame have been taken; 1 = strobe from the first sample, with missing history taps reading 0.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  sample available
in_ready  out  1  block accepts sample this cycle
in_data  in  DATA_W  signed sample x[n]
in_mu  in  DATA_W  signed step size associated with x[n]
in_last  in  1  x[n] is the final sample of the frame
data1_out  out  DATA_W  x[n] (newest)
data2_out  out  DATA_W  x[n-1]
data3_out  out  DATA_W  x[n-2]
data4_out  out  DATA_W  x[n-3] (oldest)
mu_out  out  DATA_W  mu of newest window entry
enable_out  out  1  one-cycle strobe: taps/mu valid this cycle
frame_done  out  1  one-cycle pulse when the frame's final window (including flush) has been strobed

Behaviour:
- Reset values:
  - All outputs 0, except in_ready = 0 during rst and 1 in the first cycle after rst.
  - Window registers 0, fill count 0, state FILL.
- Accept condition: accept = in_valid & in_ready.
  - On accept the window shifts: w1<=in_data, w2<=w1, w3<=w2, w4<=w3; mu register <= in_mu.
  - Outputs are registered: taps and strobe appear 1 cycle after accept. Fixed latency 1.
- States:
  - FILL: fill count 0..3.
    - Accepts increment the count.
    - ZERO_PRIME=0: enable_out is asserted only for the accept that brings the count to 4 (count==3 at accept).
    - ZERO_PRIME=1: every accept strobes.
    - At count==3 accept -> RUN.
  - RUN: every accept strobes.
  - FLUSH (macro only): 3 cycles, in_ready=0.
    - Each cycle shifts a 0 into w1 and strobes; mu holds the last frame mu.
    - After the 3rd cycle -> FILL.
- in_last handling:
  - Accept with in_last, state RUN or FILL, macro on: -> FLUSH.
  - Macro off: window and count clear to 0 in the cycle after the final strobe; -> FILL.
  - Short frame (fewer than 4 samples) with ZERO_PRIME=0 and macro off: no strobes; frame_done is still pulsed 1 cycle after the last accept.
- in_ready = 1 in FILL and RUN. No backpressure from downstream, which always consumes a strobe.
- frame_done coincides with the final strobe of the frame. If no strobe occurs, it pulses 1 cycle after the last accept.
- in_valid low: no shift, enable_out=0, taps hold their last values.
- Reset mid-frame or mid-flush: everything returns to reset values next cycle; the partial frame is discarded with no strobe and no frame_done.
- Arithmetic: none. Pure data movement; widths preserved, sign untouched.

Optional Feature:
- Macro TAP_WIN_FLUSH_EN.
- Defined: FLUSH state as above. After in_last, 3 extra strobes are issued with zero-shifted windows so the downstream filter drains the tail. in_ready=0 for those 3 cycles.
- Not defined: FLUSH state absent, in_ready constantly 1 outside reset, window cleared immediately after the last accept.

Decomposition:
- Shared package (filter pipeline package):
  - DATA_W default constant.
  - Q2.14 fractional-bits constant (14).
  - State enum {FILL, RUN, FLUSH}.
  - Tap-count constant NTAPS=4.
- Sub-module tap_shift_reg: NTAPS-deep DATA_W shift register with shift enable, synchronous clear and shift-in value select (sample or zero). The FSM and handshake stay in the top.

Test Plan:
- ZERO_PRIME=0; samples 1,2,3,4,5 (in_valid constant 1, mu=0x0100, in_last=0) -> first strobe in the cycle after the 4th accept with taps (4,3,2,1); next strobe (5,4,3,2); mu_out=0x0100.
- ZERO_PRIME=1; samples 0x4000, 0xC000 -> strobes with taps (0x4000,0,0,0) then (0xC000,0x4000,0,0); signs preserved.
- Macro on; frame 1..4 with in_last on 4 -> strobes (4,3,2,1), (0,4,3,2), (0,0,4,3), (0,0,0,4); in_ready=0 for exactly 3 cycles; frame_done with the last strobe; next frame restarts in FILL.
- Macro off; frame 7,8 with in_last on 8, ZERO_PRIME=0 -> no strobes; frame_done 1 cycle after 2nd accept; following sample 9 yields w=(9,0,0,0) internally, no strobe.
- Gapped in_valid (1,0,0,1,1,0,1) on samples 1..4 -> exactly one strobe, 1 cycle after the 4th accept, with taps (4,3,2,1); taps hold during gaps.
- rst asserted during the 2nd FLUSH cycle -> next cycle all outputs 0, in_ready=0 while rst is high; no further strobes or frame_done.
